accumulator_flags_16bit: RTL and testbench

Registered 16-bit accumulator stage that sits directly downstream of the 16-bit adder-subtractor. It takes a stream of operand/opcode commands over a valid/ready handshake and feeds the running accumulator and each operand into the adder-subtractor. It then latches the result together with the Z/N/C/V/U status flags and sticky overflow flags into an output register with its own valid/ready handshake. Optional signed saturation clamps results on signed overflow.

---
 rtl/accumulator_flags_16bit_pkg.sv | 40 ++++
 rtl/accumulator_flags_16bit_adder.sv | 44 ++++
 rtl/accumulator_flags_16bit.sv | 158 +++++++++++++++
 tb/tb_accumulator_flags_16bit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_flags_16bit_pkg.sv
// -----------------------------------------------------------------------------
// accumulator_flags_16bit_pkg
// Shared definitions for the 16-bit accumulator stage and its adder-subtractor:
//   - DATA_W           : datapath width
//   - op_e             : command opcodes (ADD, SUB, LOAD, CLEAR)
//   - SAT_MAX/SAT_MIN  : signed saturation limits
//   - flags_t          : bundle of the Z/N/C/V/U status flags
//   - sat_value()      : picks the clamp value from the sign of the true result
// -----------------------------------------------------------------------------
package accumulator_flags_16bit_pkg;

   localparam int DATA_W = 16;

   // Opcode encoding. Bit 0 doubles as the subtract select for the adder.
   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

   // Status flags latched alongside each result.
   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic v;
      logic u;
   } flags_t;

   // On signed overflow the true (infinite precision) result always carries
   // the sign of the accumulator operand, so that sign selects the clamp.
   function automatic logic [DATA_W-1:0] sat_value(input logic acc_sign);
      return acc_sign ? SAT_MIN : SAT_MAX;
   endfunction

endpackage

// File: rtl/accumulator_flags_16bit_adder.sv
// -----------------------------------------------------------------------------
// AdderSubtractor16BitOverflow
// Combinational 16-bit adder-subtractor with carry and overflow reporting.
// Ports:
//   a, b              : operands
//   sub               : 0 = a + b, 1 = a - b
//   result            : a +/- b modulo 2^16
//   carry_out         : raw carry out of the adder (for SUB, 1 means no borrow)
//   signed_overflow   : two's complement overflow
//   unsigned_overflow : carry for ADD, borrow for SUB
//   zero, negative    : flags of the raw result
// -----------------------------------------------------------------------------
module AdderSubtractor16BitOverflow
   import accumulator_flags_16bit_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              signed_overflow,
   output logic              unsigned_overflow,
   output logic              zero,
   output logic              negative
);

   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum_wide;

   // Subtraction is done as a + ~b + 1, so the carry-in equals sub.
   assign b_eff    = sub ? ~b : b;
   assign sum_wide = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};

   // Overflow happens when both effective operands share a sign that the
   // sum does not; unsigned overflow is carry for ADD and borrow for SUB.
   assign result            = sum_wide[DATA_W-1:0];
   assign carry_out         = sum_wide[DATA_W];
   assign signed_overflow   = (a[DATA_W-1] == b_eff[DATA_W-1]) &&
                              (sum_wide[DATA_W-1] != a[DATA_W-1]);
   assign unsigned_overflow = sub ? ~sum_wide[DATA_W] : sum_wide[DATA_W];
   assign zero              = (sum_wide[DATA_W-1:0] == '0);
   assign negative          = sum_wide[DATA_W-1];

endmodule

// File: rtl/accumulator_flags_16bit.sv
// -----------------------------------------------------------------------------
// accumulator_flags_16bit
// Registered accumulator stage. Accepts ADD/SUB/LOAD/CLEAR commands over a
// valid/ready handshake, computes against the current accumulator, and holds
// the result plus Z/N/C/V/U flags in a single-entry output register.
// Parameters:
//   SATURATE      : 1 = clamp to 7FFF/8000 on signed overflow, 0 = wrap
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid/in_ready, in_op, in_data : command handshake and payload
//   clr_sticky    : clears sticky_v/sticky_u (an accept that sets them wins)
//   out_valid/out_ready : result handshake
//   acc           : accumulator / result register
//   zero_flag, negative_flag, carry_flag, v_flag, u_flag : last result flags
//   sticky_v, sticky_u : accumulated overflow history
// -----------------------------------------------------------------------------
module accumulator_flags_16bit
   import accumulator_flags_16bit_pkg::*;
#(
   parameter bit SATURATE = 1'b0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [DATA_W-1:0] in_data,
   input  logic              clr_sticky,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] acc,
   output logic              zero_flag,
   output logic              negative_flag,
   output logic              carry_flag,
   output logic              v_flag,
   output logic              u_flag,
   output logic              sticky_v,
   output logic              sticky_u
);

   logic              accept;
   logic [DATA_W-1:0] add_result;
   logic              add_carry;
   logic              add_v;
   logic              add_u;
   logic              add_zero;
   logic              add_negative;
   logic              unused_add_flags;

   logic [DATA_W-1:0] raw_result;
   logic [DATA_W-1:0] next_result;
   flags_t            next_flags;

   // Single-entry buffer: a new command can enter whenever the slot is empty
   // or is being drained in this same cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   AdderSubtractor16BitOverflow u_addsub (
      .a                 (acc),
      .b                 (in_data),
      .sub               (in_op[0]),
      .result            (add_result),
      .carry_out         (add_carry),
      .signed_overflow   (add_v),
      .unsigned_overflow (add_u),
      .zero              (add_zero),
      .negative          (add_negative)
   );

   // Zero/negative from the adder describe the pre-saturation value, so they
   // are recomputed below from the value actually stored.
   assign unused_add_flags = add_zero ^ add_negative;

   // Opcode mux followed by the saturation mux. Only ADD/SUB can overflow,
   // so LOAD/CLEAR leave carry/v/u at zero. Z and N always describe the
   // value that will actually land in the accumulator.
   always_comb begin
      raw_result          = '0;
      next_flags          = '0;
      case (op_e'(in_op))
         OP_ADD, OP_SUB: begin
            raw_result       = add_result;
            next_flags.carry = add_carry;
            next_flags.v     = add_v;
            next_flags.u     = add_u;
         end
         OP_LOAD: begin
            raw_result = in_data;
         end
         OP_CLEAR: begin
            raw_result = '0;
         end
      endcase

      next_result = raw_result;
      if (SATURATE && next_flags.v) begin
         next_result = sat_value(acc[DATA_W-1]);
      end

      next_flags.zero     = (next_result == '0);
      next_flags.negative = next_result[DATA_W-1];
   end

   // Result and flag register. Only an accepted command changes it, so the
   // contents stay frozen while the consumer applies backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc           <= '0;
         zero_flag     <= 1'b1;
         negative_flag <= 1'b0;
         carry_flag    <= 1'b0;
         v_flag        <= 1'b0;
         u_flag        <= 1'b0;
      end else if (accept) begin
         acc           <= next_result;
         zero_flag     <= next_flags.zero;
         negative_flag <= next_flags.negative;
         carry_flag    <= next_flags.carry;
         v_flag        <= next_flags.v;
         u_flag        <= next_flags.u;
      end
   end

   // Output valid: set by any accept (including one that coincides with a
   // drain), cleared when the consumer drains without a replacement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky overflow history. A set from an accepted overflow takes priority
   // over a simultaneous clear so that no overflow event is ever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_v <= 1'b0;
         sticky_u <= 1'b0;
      end else begin
         if (accept && next_flags.v) begin
            sticky_v <= 1'b1;
         end else if (clr_sticky) begin
            sticky_v <= 1'b0;
         end
         if (accept && next_flags.u) begin
            sticky_u <= 1'b1;
         end else if (clr_sticky) begin
            sticky_u <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_accumulator_flags_16bit.sv
// -----------------------------------------------------------------------------
// tb_accumulator_flags_16bit
// Directed bench for accumulator_flags_16bit. Two instances share the same
// stimulus: one wrapping (SATURATE=0) and one saturating (SATURATE=1).
// -----------------------------------------------------------------------------
module tb_accumulator_flags_16bit;
   import accumulator_flags_16bit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  in_op;
   logic [15:0] in_data;
   logic        clr_sticky;
   logic        out_ready;

   logic        in_ready_w, out_valid_w;
   logic [15:0] acc_w;
   logic        zero_w, neg_w, carry_w, v_w, u_w, sticky_v_w, sticky_u_w;

   logic        in_ready_s, out_valid_s;
   logic [15:0] acc_s;
   logic        zero_s, neg_s, carry_s, v_s, u_s, sticky_v_s, sticky_u_s;

   int vectors     = 0;
   int miscompares = 0;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   accumulator_flags_16bit #(.SATURATE(1'b0)) dut_wrap (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready_w),
      .in_op         (in_op),
      .in_data       (in_data),
      .clr_sticky    (clr_sticky),
      .out_valid     (out_valid_w),
      .out_ready     (out_ready),
      .acc           (acc_w),
      .zero_flag     (zero_w),
      .negative_flag (neg_w),
      .carry_flag    (carry_w),
      .v_flag        (v_w),
      .u_flag        (u_w),
      .sticky_v      (sticky_v_w),
      .sticky_u      (sticky_u_w)
   );

   accumulator_flags_16bit #(.SATURATE(1'b1)) dut_sat (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready_s),
      .in_op         (in_op),
      .in_data       (in_data),
      .clr_sticky    (clr_sticky),
      .out_valid     (out_valid_s),
      .out_ready     (out_ready),
      .acc           (acc_s),
      .zero_flag     (zero_s),
      .negative_flag (neg_s),
      .carry_flag    (carry_s),
      .v_flag        (v_s),
      .u_flag        (u_s),
      .sticky_v      (sticky_v_s),
      .sticky_u      (sticky_u_s)
   );

   // One comparison: counts it, and on a mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs on the falling edge, then returns 1 ns after
   // the following rising edge so outputs can be sampled.
   task automatic applyStimulus(input logic valid, input logic [1:0] op,
                                input logic [15:0] data, input logic ready,
                                input logic clr);
      @(negedge clk);
      in_valid   = valid;
      in_op      = op;
      in_data    = data;
      out_ready  = ready;
      clr_sticky = clr;
      @(posedge clk);
      #1;
   endtask

   // Flag vectors below are packed as {zero, negative, carry, v, u}.
   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_op      = OP_ADD;
      in_data    = 16'h0000;
      clr_sticky = 1'b0;
      out_ready  = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset acc",        acc_w, 16'h0000);
      checkOutput("reset flags",      {zero_w, neg_w, carry_w, v_w, u_w}, 5'b10000);
      checkOutput("reset sticky",     {sticky_v_w, sticky_u_w}, 2'b00);
      checkOutput("reset valid/rdy",  {out_valid_w, in_ready_w}, 2'b01);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD then SUB into a negative result with borrow
      applyStimulus(1'b1, OP_ADD, 16'h0005, 1'b1, 1'b0);
      checkOutput("add5 acc",         acc_w, 16'h0005);
      checkOutput("add5 flags",       {zero_w, neg_w, carry_w, v_w, u_w}, 5'b00000);
      checkOutput("add5 valid/rdy",   {out_valid_w, in_ready_w}, 2'b11);
      applyStimulus(1'b1, OP_SUB, 16'h0007, 1'b1, 1'b0);
      checkOutput("sub7 acc",         acc_w, 16'h FFFE);
      checkOutput("sub7 flags",       {zero_w, neg_w, carry_w, v_w, u_w}, 5'b01001);
      checkOutput("sub7 sticky",      {sticky_v_w, sticky_u_w}, 2'b01);

      // Positive overflow: wrap vs saturate
      applyStimulus(1'b1, OP_LOAD, 16'h7FFF, 1'b1, 1'b0);
      checkOutput("load7fff acc",     acc_w, 16'h7FFF);
      checkOutput("load7fff flags",   {zero_w, neg_w, carry_w, v_w, u_w}, 5'b00000);
      applyStimulus(1'b1, OP_ADD, 16'h0001, 1'b1, 1'b0);
      checkOutput("ovf wrap acc",     acc_w, 16'h8000);
      checkOutput("ovf wrap flags",   {zero_w, neg_w, carry_w, v_w, u_w}, 5'b01010);
      checkOutput("ovf wrap sticky",  {sticky_v_w, sticky_u_w}, 2'b11);
      checkOutput("ovf sat acc",      acc_s, 16'h7FFF);
      checkOutput("ovf sat flags",    {zero_s, neg_s, carry_s, v_s, u_s}, 5'b00010);
      checkOutput("ovf sat sticky",   {sticky_v_s, sticky_u_s}, 2'b11);

      // Sticky clear alone, then set-wins-over-clear with negative overflow
      applyStimulus(1'b0, OP_ADD, 16'h0000, 1'b1, 1'b1);
      checkOutput("clr sticky",       {sticky_v_w, sticky_u_w}, 2'b00);
      checkOutput("clr valid/rdy",    {out_valid_w, in_ready_w}, 2'b01);
      applyStimulus(1'b1, OP_LOAD, 16'h8000, 1'b1, 1'b0);
      checkOutput("load8000 flags",   {zero_w, neg_w, carry_w, v_w, u_w}, 5'b01000);
      applyStimulus(1'b1, OP_SUB, 16'h0001, 1'b1, 1'b1);
      checkOutput("negovf wrap acc",  acc_w, 16'h7FFF);
      checkOutput("negovf wrap flags",{zero_w, neg_w, carry_w, v_w, u_w}, 5'b00110);
      checkOutput("set wins sticky",  {sticky_v_w, sticky_u_w}, 2'b10);
      checkOutput("negovf sat acc",   acc_s, 16'h8000);
      checkOutput("negovf sat flags", {zero_s, neg_s, carry_s, v_s, u_s}, 5'b01110);
      applyStimulus(1'b0, OP_ADD, 16'h0000, 1'b1, 1'b1);
      checkOutput("clr again sticky", {sticky_v_w, sticky_u_w}, 2'b00);

      // Backpressure: one accepted, three held, then released
      applyStimulus(1'b1, OP_LOAD, 16'h0010, 1'b0, 1'b0);
      checkOutput("bp load acc",      acc_w, 16'h0010);
      checkOutput("bp load valid/rdy",{out_valid_w, in_ready_w}, 2'b10);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, OP_ADD, 16'h0001, 1'b0, 1'b0);
         checkOutput("bp stall acc",       acc_w, 16'h0010);
         checkOutput("bp stall flags",     {zero_w, neg_w, carry_w, v_w, u_w}, 5'b00000);
         checkOutput("bp stall valid/rdy", {out_valid_w, in_ready_w}, 2'b10);
      end
      applyStimulus(1'b1, OP_ADD, 16'h0001, 1'b1, 1'b0);
      checkOutput("bp rel1 acc",      acc_w, 16'h0011);
      checkOutput("bp rel1 valid/rdy",{out_valid_w, in_ready_w}, 2'b11);
      applyStimulus(1'b1, OP_ADD, 16'h0002, 1'b1, 1'b0);
      checkOutput("bp rel2 acc",      acc_w, 16'h0013);
      applyStimulus(1'b1, OP_SUB, 16'h0003, 1'b1, 1'b0);
      checkOutput("bp rel3 acc",      acc_w, 16'h0010);
      checkOutput("bp rel3 flags",    {zero_w, neg_w, carry_w, v_w, u_w}, 5'b00100);
      applyStimulus(1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
      checkOutput("bp drain valid",   {out_valid_w, in_ready_w}, 2'b01);
      checkOutput("bp drain acc",     acc_w, 16'h0010);

      // Asynchronous reset while a result is pending
      applyStimulus(1'b1, OP_LOAD, 16'h1234, 1'b0, 1'b0);
      checkOutput("pre-rst acc",      acc_w, 16'h1234);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkOutput("async rst acc",    acc_w, 16'h0000);
      checkOutput("async rst flags",  {zero_w, neg_w, carry_w, v_w, u_w}, 5'b10000);
      checkOutput("async rst valid",  {out_valid_w, in_ready_w}, 2'b01);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, OP_ADD, 16'h0003, 1'b1, 1'b0);
      checkOutput("post-rst add acc", acc_w, 16'h0003);

      // CLEAR after FFFF, and CLEAR wiping a set carry/u
      applyStimulus(1'b1, OP_LOAD, 16'hFFFF, 1'b1, 1'b0);
      checkOutput("loadffff flags",   {zero_w, neg_w, carry_w, v_w, u_w}, 5'b01000);
      applyStimulus(1'b1, OP_CLEAR, 16'h1234, 1'b1, 1'b0);
      checkOutput("clear acc",        acc_w, 16'h0000);
      checkOutput("clear flags",      {zero_w, neg_w, carry_w, v_w, u_w}, 5'b10000);
      checkOutput("clear sat acc",    acc_s, 16'h0000);
      applyStimulus(1'b1, OP_ADD, 16'hFFFF, 1'b1, 1'b0);
      applyStimulus(1'b1, OP_ADD, 16'h0001, 1'b1, 1'b0);
      checkOutput("carry wrap acc",   acc_w, 16'h0000);
      checkOutput("carry wrap flags", {zero_w, neg_w, carry_w, v_w, u_w}, 5'b10101);
      applyStimulus(1'b1, OP_CLEAR, 16'hFFFF, 1'b1, 1'b0);
      checkOutput("clear2 flags",     {zero_w, neg_w, carry_w, v_w, u_w}, 5'b10000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
